// File: rtl/ifp_pkg.sv
// Shared encodings and phase-length helpers for the ifp array sequencer.
package ifp_pkg;

  // PE phase encodings broadcast on state_o
  localparam logic [1:0] STOP_ST = 2'b00;
  localparam logic [1:0] COST_ST = 2'b01;
  localparam logic [1:0] ROOT_ST = 2'b10;
  localparam logic [1:0] SAVE_ST = 2'b11;

  // Data-type encodings
  localparam logic C8L16 = 1'b0;
  localparam logic C16L8 = 1'b1;

  // Per-PE register image: changed 1, seed 1, pred 4, label 8, complement 8, cost 8, bright 8
  localparam int unsigned SHIFT_BITS = 38;
  localparam int unsigned SAVE_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP,
    UNLOAD
  } fsm_state_e;

  function automatic int unsigned cost_len(input logic data_type);
    return (data_type == C16L8) ? 16 : 8;
  endfunction

  function automatic int unsigned root_len(input logic data_type);
    return (data_type == C8L16) ? 16 : 8;
  endfunction

endpackage

// File: rtl/ifp_sequencer_if.sv
// Broadcast control bundle between the sequencer and the ifp PE array.
interface ifp_sequencer_if;
  logic       run_o;
  logic [1:0] state_o;
  logic       direction_o;
  logic       carry_in_o;
  logic       mem_send_o;
  logic       mem_receive_o;
  logic [1:0] pathfunction_o;
  logic       neighborhood_o;
  logic       data_type_o;
  logic       activity_i;

  modport master (
    output run_o, state_o, direction_o, carry_in_o, mem_send_o, mem_receive_o,
    output pathfunction_o, neighborhood_o, data_type_o,
    input  activity_i
  );

  modport slave (
    input  run_o, state_o, direction_o, carry_in_o, mem_send_o, mem_receive_o,
    input  pathfunction_o, neighborhood_o, data_type_o,
    output activity_i
  );
endinterface

// File: rtl/ifp_bit_counter.sv
// Loadable down-counter with terminal-count flag; times shift and phase lengths.
module ifp_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_val_i;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc_o = (count == '0);

endmodule

// File: rtl/ifp_sequencer.sv
// Sequencer for the ifp PE chain: shift image in, run propagation sweeps, shift results out.
module ifp_sequencer
  import ifp_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned ACT_LAT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        cfg_pathfunction_i,
  input  logic              cfg_neighborhood_i,
  input  logic              cfg_data_type_i,
  input  logic [ITER_W-1:0] cfg_max_iter_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              converged_o,
  output logic [ITER_W-1:0] iter_o,
  ifp_sequencer_if.master   pe
);

  localparam int unsigned SHIFT_CYCLES = SHIFT_BITS * CHAIN_LEN;
  localparam int unsigned CNT_W        = $clog2(SHIFT_CYCLES);
  localparam int unsigned LAT_W        = (ACT_LAT < 1) ? 1 : $clog2(ACT_LAT + 1);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(SHIFT_CYCLES - 1);

  fsm_state_e        fsm_q, fsm_d;
  logic [1:0]        state_d;
  logic              dir_d, run_d, carry_d, send_d, recv_d, done_d, conv_d;
  logic [ITER_W-1:0] iter_d, iter_sat, iter_lim;
  logic              cfg_latch, cnt_load, cnt_tc, leave_cost;
  logic [CNT_W-1:0]  cnt_val;
  logic [LAT_W-1:0]  post_cnt;
  logic              act_q, act_win, iter_start;

  ifp_bit_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  assign iter_sat   = (iter_o == '1) ? iter_o : iter_o + 1'b1;
  assign iter_lim   = (cfg_max_iter_i == '0) ? ITER_W'(1) : cfg_max_iter_i;
  assign act_win    = ((fsm_q == SWEEP) && (pe.state_o == COST_ST)) || (post_cnt != '0);
  assign iter_start = (fsm_q == SWEEP) && (pe.state_o == STOP_ST) && !pe.direction_o;

  // Next-state and phase sequencing; counter is loaded with (length-1) on each phase entry
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = pe.state_o;
    dir_d      = pe.direction_o;
    run_d      = pe.run_o;
    carry_d    = 1'b0;
    send_d     = pe.mem_send_o;
    recv_d     = pe.mem_receive_o;
    done_d     = 1'b0;
    conv_d     = converged_o;
    iter_d     = iter_o;
    cfg_latch  = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    leave_cost = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d     = LOAD;
          send_d    = 1'b1;
          iter_d    = '0;
          conv_d    = 1'b0;
          cfg_latch = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = SHIFT_LOAD;
        end
      end
      LOAD: begin
        if (cnt_tc) begin
          fsm_d    = SWEEP;
          send_d   = 1'b0;
          run_d    = 1'b1;
          state_d  = STOP_ST;
          dir_d    = 1'b0;
          cnt_load = 1'b1;
        end
      end
      SWEEP: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          case (pe.state_o)
            STOP_ST: begin
              state_d = COST_ST;
              cnt_val = CNT_W'(cost_len(pe.data_type_o) - 1);
            end
            COST_ST: begin
              state_d    = ROOT_ST;
              carry_d    = 1'b1;
              leave_cost = 1'b1;
              cnt_val    = CNT_W'(root_len(pe.data_type_o) - 1);
            end
            ROOT_ST: begin
              state_d = SAVE_ST;
              cnt_val = CNT_W'(SAVE_BITS - 1);
            end
            SAVE_ST: begin
              state_d = STOP_ST;
              if (!pe.direction_o) begin
                dir_d = 1'b1;
              end else begin
                dir_d  = 1'b0;
                iter_d = iter_sat;
                if (!act_q || (iter_sat >= iter_lim)) begin
                  fsm_d   = UNLOAD;
                  run_d   = 1'b0;
                  recv_d  = 1'b1;
                  conv_d  = !act_q;
                  cnt_val = SHIFT_LOAD;
                end
              end
            end
          endcase
        end
      end
      UNLOAD: begin
        if (cnt_tc) begin
          fsm_d  = IDLE;
          recv_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Abort overrides whatever the case above decided, including a same-cycle start
    if (abort_i) begin
      fsm_d      = IDLE;
      state_d    = STOP_ST;
      dir_d      = 1'b0;
      run_d      = 1'b0;
      carry_d    = 1'b0;
      send_d     = 1'b0;
      recv_d     = 1'b0;
      done_d     = 1'b0;
      conv_d     = converged_o;
      iter_d     = iter_o;
      cfg_latch  = 1'b0;
      cnt_load   = 1'b0;
      leave_cost = 1'b0;
    end
  end

  // Registered FSM state and all outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q             <= IDLE;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      converged_o       <= 1'b0;
      iter_o            <= '0;
      pe.run_o          <= 1'b0;
      pe.state_o        <= STOP_ST;
      pe.direction_o    <= 1'b0;
      pe.carry_in_o     <= 1'b0;
      pe.mem_send_o     <= 1'b0;
      pe.mem_receive_o  <= 1'b0;
      pe.pathfunction_o <= '0;
      pe.neighborhood_o <= 1'b0;
      pe.data_type_o    <= 1'b0;
    end else begin
      fsm_q            <= fsm_d;
      busy_o           <= (fsm_d != IDLE);
      done_o           <= done_d;
      converged_o      <= conv_d;
      iter_o           <= iter_d;
      pe.run_o         <= run_d;
      pe.state_o       <= state_d;
      pe.direction_o   <= dir_d;
      pe.carry_in_o    <= carry_d;
      pe.mem_send_o    <= send_d;
      pe.mem_receive_o <= recv_d;
      if (cfg_latch) begin
        pe.pathfunction_o <= cfg_pathfunction_i;
        pe.neighborhood_o <= cfg_neighborhood_i;
        pe.data_type_o    <= cfg_data_type_i;
      end
    end
  end

  // Post-COST acceptance window covering the PE passage-register latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      post_cnt <= '0;
    end else if (abort_i) begin
      post_cnt <= '0;
    end else if (leave_cost) begin
      post_cnt <= LAT_W'(ACT_LAT);
    end else if (post_cnt != '0) begin
      post_cnt <= post_cnt - 1'b1;
    end
  end

  // Sticky per-iteration activity flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= 1'b0;
    end else if (iter_start) begin
      act_q <= 1'b0;
    end else if (act_win && pe.activity_i) begin
      act_q <= 1'b1;
    end
  end

endmodule

// File: doc/ifp_sequencer.md
# ifp_sequencer

Control sequencer for a serial chain of bit-serial image-foresting processing elements (the `ifp` array). It first shifts the per-PE register image into the chain (`mem_send`). It then runs forward/backward propagation sweeps of STOP→COST→ROOT→SAVE phases until the array reports no activity or an iteration limit is reached. Finally it shifts the results out (`mem_receive`). It sits between the host/AXI control registers and the broadcast control inputs of the PE array.

## Interface
Parameters:
- `CHAIN_LEN`, 4: number of PEs in the serial shift chain.
- `ITER_W`, 8: width of the iteration limit and iteration counter.
- `ACT_LAT`, 2: extra cycles after the COST phase during which `activity_i` is still accepted; covers the PE passage-register latency.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: start request; sampled only in IDLE.
- `abort_i`, in, 1: synchronous abort to IDLE; no `done_o` is produced.
- `cfg_pathfunction_i`, in, 2: path function; latched at start.
- `cfg_neighborhood_i`, in, 1: neighbourhood select; latched at start.
- `cfg_data_type_i`, in, 1: 0 = C8L16, 1 = C16L8; latched at start.
- `cfg_max_iter_i`, in, ITER_W: iteration limit; 0 is treated as 1.
- `activity_i`, in, 1: wired-OR of the PE `transmit_data` signals across the array.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse when UNLOAD completes.
- `converged_o`, out, 1: valid with `done_o`; 1 means the run stopped on zero activity rather than the limit.
- `iter_o`, out, ITER_W: number of completed iterations; holds its value after done until the next start.
- `run_o`, `state_o[1:0]`, `direction_o`, `carry_in_o`, `mem_send_o`, `mem_receive_o`, out: PE control broadcast.
- `pathfunction_o[1:0]`, `neighborhood_o`, `data_type_o`, out: latched configuration, driven to the PEs.

All outputs are registered. On reset every output is 0; `state_o` = STOP (00).

## Operation
- FSM states: IDLE, LOAD, SWEEP, UNLOAD.
- IDLE:
  - All PE controls are 0.
  - `start_i`=1 latches the configuration, clears `iter_o`, and moves to LOAD.
- LOAD:
  - `mem_send_o`=1 and `run_o`=0 for exactly SHIFT_BITS*CHAIN_LEN cycles. SHIFT_BITS = 38 (changed 1, seed 1, pred 4, label 8, complement 8, cost 8, bright 8).
  - Then moves to SWEEP with `direction_o`=0.
- SWEEP:
  - `run_o`=1 throughout.
  - Phase lengths:
    - STOP: 1 cycle.
    - COST: C cycles, C = 8 for C8L16 and 16 for C16L8.
    - ROOT: R cycles, R = 16 for C8L16 and 8 for C16L8.
    - SAVE: 4 cycles.
  - One sweep is 29 cycles for either data type.
  - `carry_in_o`=1 on the first ROOT cycle only.
  - An iteration is one sweep with `direction_o`=0 followed by one with `direction_o`=1.
- Activity flag:
  - The sticky activity flag is cleared on the first STOP cycle of each iteration.
  - It is set if `activity_i`=1 during any COST cycle, or during the ACT_LAT cycles that follow, in either sweep.
- End of the direction-1 SAVE phase:
  - `iter_o` increments.
  - If activity = 0, set `converged_o`=1 and go to UNLOAD.
  - Else if `iter_o` (new value) ≥ max(`cfg_max_iter_i`, 1), set `converged_o`=0 and go to UNLOAD.
  - Otherwise start the next iteration at STOP with direction 0.
- UNLOAD:
  - `mem_receive_o`=1, `run_o`=0, `state_o`=STOP for SHIFT_BITS*CHAIN_LEN cycles.
  - Then `done_o` pulses and the FSM returns to IDLE.
- `start_i` is ignored while `busy_o`=1.
- `abort_i` takes precedence over every transition. On the next edge the FSM is in IDLE with all PE controls 0; `iter_o` holds its value.
- Reset mid-operation: immediate return to the IDLE output state. No `done_o` is produced and the PE contents are undefined.
- Counter width: the phase/shift counter is ceil(log2(38*CHAIN_LEN)) bits. `iter_o` saturates at 2^ITER_W−1; no wrap-around.

## Timing
- `start_i` high at edge k gives `mem_send_o`=1 from cycle k+1.
- `mem_send_o` and `mem_receive_o` are never high at the same time as each other or as `run_o`. There is no gap cycle between LOAD and the first STOP, or between the final SAVE and UNLOAD.
- `state_o` and `direction_o` change only at phase and sweep boundaries. `direction_o` toggles on the STOP cycle.
- Total run time is 2·38·CHAIN_LEN + 58·N cycles (N = number of iterations), followed by one `done_o` cycle.
- `done_o` and the IDLE transition occur on the same edge. A new `start_i` is accepted on the cycle after `done_o`.

## Structure
- Package `ifp_pkg` holds:
  - State encodings STOP_ST=00, COST_ST=01, ROOT_ST=10, SAVE_ST=11.
  - Data-type encodings C8L16=0, C16L8=1.
  - SHIFT_BITS=38 and SAVE_BITS=4.
  - Phase-length functions of the data type.
  - The FSM state typedef.
- One sub-module, `ifp_bit_counter`: a loadable down-counter with a terminal-count flag, used for both the shift and phase lengths.

## Test plan
- CHAIN_LEN=2, C8L16, max_iter=5, `activity_i` stuck at 0 → 76 `mem_send_o` cycles, then one iteration (58 cycles: phase sequence 1/8/16/4 per sweep), then 76 `mem_receive_o` cycles. `done_o` pulses with `iter_o`=1 and `converged_o`=1.
- C16L8, `activity_i` pulsed on cycle 3 of COST in every iteration, max_iter=3 → COST lasts 16 cycles and ROOT 8. Done arrives with `iter_o`=3 and `converged_o`=0.
- Activity pulsed only in iterations 1–2, max_iter=10 → `iter_o`=3, `converged_o`=1. An `activity_i` pulse at the 2nd cycle after COST ends (ACT_LAT=2) still counts; one at the 3rd cycle does not.
- `abort_i` during a ROOT phase → the next cycle shows IDLE with all PE controls 0 and no `done_o`. A following `start_i` restarts at LOAD.
- `rst_ni` low during UNLOAD → all outputs are 0 asynchronously. `start_i` pulsed during SWEEP is ignored.
- `cfg_max_iter_i`=0 with continuous activity → exactly one iteration runs, then UNLOAD with `converged_o`=0.
